// File: rtl/uart_pkg.sv
// Shared state encoding, error codes and default sync marker for the UART frame parser.
package uart_pkg;

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, DRAIN} state_t;

  localparam logic [1:0] ERR_LEN = 2'd0;
  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam logic [1:0] ERR_OVR = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x DATA_BITS registers, synchronous write, combinational read, no reset.
module uart_frame_buf #(
  parameter int  DATA_BITS = 8,
  parameter int  DEPTH     = 16,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        wr_ptr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [AW-1:0]        rd_ptr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/uart_frame_parser.sv
// Sync-hunting length-prefixed frame parser; payload replays on valid/ready one cycle after the last byte,
// stalls under backpressure and drops bytes arriving during drain as overrun. UART_FRAME_CHK_EN adds an XOR checksum byte.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int          DATA_BITS      = 8,
  parameter int          MAX_LEN        = 16,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DFLT,
  parameter int          TIMEOUT_CYCLES = 2048,
  localparam int         LEN_W          = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rx_valid,
  input  logic [DATA_BITS-1:0] rx_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_last,
  output logic [LEN_W-1:0]     frame_len,
  output logic                 busy,
  output logic                 err_valid,
  output logic [1:0]           err_code
);

  localparam int                   AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int                   TMO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_BITS-1:0] MAX_LEN_B = DATA_BITS'(MAX_LEN);

  state_t               state;
  logic [LEN_W-1:0]     len;
  logic [LEN_W-1:0]     wr_ptr;
  logic [LEN_W-1:0]     rd_ptr;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [DATA_BITS-1:0] rdata;
  logic                 in_frame;
  logic                 tmo_hit;
  logic                 last_byte;
  logic                 drain_go;

  assign in_frame  = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign last_byte = (state == PAYLOAD) && rx_valid && ((wr_ptr + LEN_W'(1)) == len);

`ifdef UART_FRAME_CHK_EN
  logic [DATA_BITS-1:0] chk;
  assign drain_go = (state == CHK) && rx_valid && (rx_data == chk);
`else
  assign drain_go = last_byte;
`endif

  uart_frame_buf #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (MAX_LEN)
  ) u_buf (
    .clk    (clk),
    .we     ((state == PAYLOAD) && rx_valid),
    .wr_ptr (wr_ptr[AW-1:0]),
    .wdata  (rx_data),
    .rd_ptr (rd_ptr[AW-1:0]),
    .rdata  (rdata)
  );

  assign busy     = (state != HUNT);
  // Buffer is unreset, so gate it to keep out_data at zero outside a drain.
  assign out_data = out_valid ? rdata : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= HUNT;
      len       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tmo_cnt   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_len <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
`ifdef UART_FRAME_CHK_EN
      chk       <= '0;
`endif
    end else begin
      err_valid <= 1'b0;
      // Counter rests at zero outside a frame: every exit clears it via a byte or the timeout itself.
      if (in_frame) tmo_cnt <= (rx_valid || tmo_hit) ? '0 : tmo_cnt + TMO_W'(1);

      case (state)
        HUNT: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) state <= LEN;
        end
        LEN: begin
          if (rx_valid) begin
            if ((rx_data == '0) || (rx_data > MAX_LEN_B)) begin
              state     <= HUNT;
              err_valid <= 1'b1;
              err_code  <= ERR_LEN;
            end else begin
              len    <= rx_data[LEN_W-1:0];
              wr_ptr <= '0;
              state  <= PAYLOAD;
`ifdef UART_FRAME_CHK_EN
              chk    <= rx_data;
`endif
            end
          end
        end
        PAYLOAD: begin
          if (rx_valid) begin
            wr_ptr <= wr_ptr + LEN_W'(1);
`ifdef UART_FRAME_CHK_EN
            chk    <= chk ^ rx_data;
            if (last_byte) state <= CHK;
`endif
          end
        end
`ifdef UART_FRAME_CHK_EN
        CHK: begin
          if (rx_valid && !drain_go) begin
            state     <= HUNT;
            err_valid <= 1'b1;
            err_code  <= ERR_CHK;
          end
        end
`endif
        DRAIN: begin
          if (rx_valid) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OVR;
          end
          if (out_ready) begin
            if (out_last) begin
              state     <= HUNT;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              rd_ptr    <= '0;
            end else begin
              rd_ptr   <= rd_ptr + LEN_W'(1);
              out_last <= ((rd_ptr + LEN_W'(2)) == len);
            end
          end
        end
        default: state <= HUNT;
      endcase

      if (in_frame && !rx_valid && tmo_hit) begin
        state     <= HUNT;
        err_valid <= 1'b1;
        err_code  <= ERR_TMO;
      end

      if (drain_go) begin
        state     <= DRAIN;
        out_valid <= 1'b1;
        rd_ptr    <= '0;
        out_last  <= (len == LEN_W'(1));
        frame_len <= len;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: scoreboarded payload and error streams, checked at the falling edge.
module tb_uart_frame_parser;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [4:0] frame_len;
  logic       busy;
  logic       err_valid;
  logic [1:0] err_code;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic [4:0] len;
  } exp_t;
  typedef logic [7:0] byte_q_t [$];

  exp_t       exp_q [$];
  logic [1:0] err_q [$];
  int         checks = 0;
  int         errors = 0;
  int         hs_cnt = 0;

  always #5 clk = ~clk;

  uart_frame_parser dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_len (frame_len),
    .busy      (busy),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs at a falling edge, with out_ready already set for the coming rising edge.
  task automatic monitor();
    exp_t e;
    if (out_valid && out_ready) begin
      hs_cnt++;
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.d));
        check("out_last", 32'(out_last), 32'(e.last));
        check("frame_len", 32'(frame_len), 32'(e.len));
      end
    end
    if (err_valid) begin
      check("err_expected", 32'(err_q.size() != 0), 32'd1);
      if (err_q.size() != 0) check("err_code", 32'(err_code), 32'(err_q.pop_front()));
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    monitor();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic send_frame(input byte_q_t pl);
    exp_t e;
`ifdef UART_FRAME_CHK_EN
    logic [7:0] c;
    c = 8'(pl.size());
`endif
    for (int i = 0; i < pl.size(); i++) begin
      e.d    = pl[i];
      e.last = (i == pl.size() - 1);
      e.len  = 5'(pl.size());
      exp_q.push_back(e);
    end
    cyc(1'b1, 8'hA5);
    cyc(1'b1, 8'(pl.size()));
    foreach (pl[i]) begin
      cyc(1'b1, pl[i]);
`ifdef UART_FRAME_CHK_EN
      c = c ^ pl[i];
`endif
    end
`ifdef UART_FRAME_CHK_EN
    cyc(1'b1, c);
`endif
  endtask

  initial begin
    byte_q_t pl;
    exp_t    e;
    int      h0;

    n_rst     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Basic 3-byte frame, consumer always ready.
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(pl);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_data", 32'(out_data), 32'h11);
    check("drain_busy", 32'(busy), 32'd1);
    h0 = hs_cnt;
    idle(3);
    check("drain_cycles", 32'(hs_cnt - h0), 32'd3);
    check("post_drain_valid", 32'(out_valid), 32'd0);
    check("post_drain_busy", 32'(busy), 32'd0);

`ifdef UART_FRAME_CHK_EN
    // Corrupted checksum.
    err_q.push_back(ERR_CHK);
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h03); cyc(1'b1, 8'h11);
    cyc(1'b1, 8'h22); cyc(1'b1, 8'h33); cyc(1'b1, 8'hFF);
    check("badchk_out_valid", 32'(out_valid), 32'd0);
    check("badchk_busy", 32'(busy), 32'd0);
    idle(3);
`endif

    // Garbage ignored, zero length and oversize length rejected.
    cyc(1'b1, 8'h00); cyc(1'b1, 8'h5A);
    check("garbage_busy", 32'(busy), 32'd0);
    err_q.push_back(ERR_LEN);
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h00);
    check("len0_busy", 32'(busy), 32'd0);
    idle(2);
    err_q.push_back(ERR_LEN);
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'd17);
    check("len17_busy", 32'(busy), 32'd0);
    idle(2);
    pl = '{8'h7E};
    send_frame(pl);
    check("len1_out_last", 32'(out_last), 32'd1);
    idle(2);

    // Maximum-length frame.
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'(i * 7 + 3));
    send_frame(pl);
    idle(17);
    check("max_drained", 32'(exp_q.size()), 32'd0);

    // Inter-byte timeout fires on the 2048th idle edge, exactly once.
    err_q.push_back(ERR_TMO);
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h02); cyc(1'b1, 8'h10);
    idle(2047);
    check("tmo_not_early", 32'(err_valid), 32'd0);
    check("tmo_busy_before", 32'(busy), 32'd1);
    idle(1);
    check("tmo_pulse", 32'(err_valid), 32'd1);
    check("tmo_busy_after", 32'(busy), 32'd0);
    idle(4);

    // Byte arriving on the terminal count wins over the timeout.
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h02);
    e = '{d: 8'h44, last: 1'b0, len: 5'd2}; exp_q.push_back(e);
    e = '{d: 8'h45, last: 1'b1, len: 5'd2}; exp_q.push_back(e);
    idle(2047);
    cyc(1'b1, 8'h44);
    check("tmo_byte_wins", 32'(err_valid), 32'd0);
    cyc(1'b1, 8'h45);
`ifdef UART_FRAME_CHK_EN
    cyc(1'b1, 8'h03);
`endif
    check("tmo_recover_valid", 32'(out_valid), 32'd1);
    idle(3);
    pl = '{8'h01, 8'h02};
    send_frame(pl);
    idle(3);

    // Backpressure with an overrun byte during drain.
    out_ready = 1'b0;
    pl = '{8'h10, 8'h20};
    send_frame(pl);
    err_q.push_back(ERR_OVR);
    cyc(1'b1, 8'h55);
    for (int i = 0; i < 9; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'h10);
      check("stall_last", 32'(out_last), 32'd0);
      check("stall_len", 32'(frame_len), 32'd2);
      idle(1);
    end
    out_ready = 1'b1;
    idle(3);
    check("bp_done", 32'(out_valid), 32'd0);

    // Sync byte on the final drain handshake is dropped as overrun.
    pl = '{8'h99};
    send_frame(pl);
    err_q.push_back(ERR_OVR);
    cyc(1'b1, 8'hA5);
    check("last_hs_busy", 32'(busy), 32'd0);
    idle(2);

    // Reset mid-frame aborts silently.
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h04); cyc(1'b1, 8'hAA);
    check("midframe_busy", 32'(busy), 32'd1);
    n_rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_frame_len", 32'(frame_len), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    idle(2);
    pl = '{8'hC3};
    send_frame(pl);
    idle(2);

    // Reset mid-drain.
    out_ready = 1'b0;
    pl = '{8'h05, 8'h06};
    send_frame(pl);
    check("predrain_valid", 32'(out_valid), 32'd1);
    n_rst = 1'b0;
    #1;
    check("arst_drain_valid", 32'(out_valid), 32'd0);
    check("arst_drain_data", 32'(out_data), 32'd0);
    check("arst_err_valid", 32'(err_valid), 32'd0);
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    out_ready = 1'b1;
    idle(3);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("err_q_empty", 32'(err_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
